// File: rtl/arith_defs.sv
// Shared arithmetic definitions: slice width, FSM encodings and the
// operand-width legality check used at elaboration time.
package arith_defs;

    // Width of one borrow look-ahead slice.
    localparam int SLICE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A legal operand width is a whole number of slices and at least two slices.
    function automatic logic width_is_legal(input int w);
        return ((w % SLICE_W) == 0) && (w >= 2 * SLICE_W);
    endfunction

endpackage : arith_defs

// File: rtl/bla4.sv
// Purely combinational 4-bit borrow look-ahead subtractor:
// diff = a - b - bin, bout = 1 when the slice needs to borrow.
// Every borrow is a flat two-level sum of products of generate/propagate
// terms, so no borrow ripples through the slice.
module bla4
    import arith_defs::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout
);

    logic [SLICE_W-1:0] g;    // bit generates a borrow on its own
    logic [SLICE_W-1:0] p;    // bit passes an incoming borrow through
    logic [SLICE_W-1:0] br;   // borrow into each bit

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_gp
            assign g[gi] = ~a[gi] & b[gi];
            assign p[gi] = ~(a[gi] ^ b[gi]);
        end
    endgenerate

    // Flattened look-ahead borrows, one product term per possible source.
    assign br[0] = bin;
    assign br[1] = g[0]
                 | (p[0] & bin);
    assign br[2] = g[1]
                 | (p[1] & g[0])
                 | (p[1] & p[0] & bin);
    assign br[3] = g[2]
                 | (p[2] & g[1])
                 | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign bout  = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign diff = a ^ b ^ br;

endmodule : bla4

// File: rtl/bla_seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, one 4-bit
// slice per clock (least significant first) through a single bla4, with a
// registered borrow linking consecutive slices. Valid/ready on both sides.
module bla_seq_subtractor
    import arith_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (!width_is_legal(WIDTH)) begin : g_width_check
            $error("bla_seq_subtractor: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl [NSLICE];
    logic [SLICE_W-1:0] b_sl [NSLICE];
    logic [SLICE_W-1:0] cur_a, cur_b;
    logic [SLICE_W-1:0] slice_diff;
    logic               slice_bout;
    logic [WIDTH-1:0]   diff_run;
    logic               last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
            assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
            // Only the slice under the counter takes the new partial result.
            assign diff_run[gi*SLICE_W +: SLICE_W] =
                (cnt_q == CW'(gi)) ? slice_diff : diff_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign cur_a      = a_sl[cnt_q];
    assign cur_b      = b_sl[cnt_q];
    assign last_slice = (cnt_q == CW'(NSLICE - 1));

    bla4 u_bla4 (
        .a    (cur_a),
        .b    (cur_b),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        bout_d    = bout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d   = diff_run;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + CW'(1);
                if (last_slice) begin
                    // Flags are taken from the fully assembled difference.
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    bout_d  = slice_bout;
                    zero_d  = (diff_run == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_run[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule : bla_seq_subtractor

// File: tb/tb_bla_seq_subtractor.sv
// Directed self-checking bench for bla_seq_subtractor (WIDTH=32) plus an
// exhaustive sweep of the standalone bla4 slice.
module tb_bla_seq_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    logic [3:0]  s_a;
    logic [3:0]  s_b;
    logic        s_bin;
    logic [3:0]  s_diff;
    logic        s_bout;

    int total = 0;
    int bad   = 0;

    bla_seq_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    bla4 u_bla4 (
        .a    (s_a),
        .b    (s_b),
        .bin  (s_bin),
        .diff (s_diff),
        .bout (s_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Wait (bounded) until the block is ready for operands.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // One full operation; hold = cycles out_ready stays low after out_valid,
    // with an ignored in_valid pulse during the hold when hold > 2.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic bv_in, input logic [31:0] exp_d, input logic exp_bout,
                          input logic exp_zero, input logic exp_ovf, input int hold);
        int n;
        wait_ready();
        a = av; b = bv; bin = bv_in; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; bin = ~bv_in;   // later input changes must not matter
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_diff"}, 64'(diff), 64'(exp_d));
        chk({tag, "_flags"}, 64'({bout, zero, ovf}), 64'({exp_bout, exp_zero, exp_ovf}));
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                a = 32'h0; b = 32'h1; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_diff"}, 64'(diff), 64'(exp_d));
            chk({tag, "_hold_flags"}, 64'({bout, zero, ovf}), 64'({exp_bout, exp_zero, exp_ovf}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        $display("op %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d zero=%0d ovf=%0d",
                 tag, av, bv, bv_in, diff, bout, zero, ovf);
    endtask

    initial begin
        int seen;
        int e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        s_a = '0; s_b = '0; s_bin = 1'b0;
        #1;
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_outs", 64'({diff, bout, zero, ovf}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, expected values worked out by hand.
        run_op("small",    32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 0);
        run_op("under",    32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("xborrow",  32'h00000010, 32'h00000001, 1'b1, 32'h0000000E, 1'b0, 1'b0, 1'b0, 0);
        run_op("ovf",      32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 0);
        run_op("equal",    32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 0);
        run_op("binonly",  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("negovf",   32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 0);
        run_op("backpres", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 5);
        run_op("after_bp", 32'h00001000, 32'h00000FFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 0);

        // Asynchronous reset between edges 3 and 4 of an operation.
        wait_ready();
        a = 32'hFFFFFFFF; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_diff", 64'(diff), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_no_result", 64'(seen), 64'd0);
        $display("op reset_mid_run: discarded, out_valid cycles afterwards=%0d", seen);
        run_op("fresh", 32'h10000000, 32'h00000001, 1'b0, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 0);

        // Exhaustive standalone slice sweep.
        for (int i = 0; i < 512; i++) begin
            s_a   = i[3:0];
            s_b   = i[7:4];
            s_bin = i[8];
            #1;
            e = int'(s_a) - int'(s_b) - int'(s_bin);
            chk("bla4", 64'({s_bout, s_diff}), 64'({(e < 0), 4'(e & 15)}));
        end
        $display("op bla4_sweep: 512 combinations checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bla_seq_subtractor
